// File: rtl/snitch_icache_lookup_sched.sv
// Shared icache lookup scheduler.
// Arbitrates NR_PORTS fetch requesters onto a single lookup stage with
// round-robin priority and a grant lock that holds a stalled request stable.
// A credit counter limits the number of lookups in flight. Responses are
// steered back to their requester by the port index carried in the ID.
// Flushes block new issues, wait for in-flight lookups to drain, hand the
// flush to the lookup stage and then pulse an acknowledge.

// Protocol checks for the scheduler, kept apart from the datapath.
module snitch_icache_lookup_sched_chk #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CW              = 2
) (
  input logic          clk_i,
  input logic          rst_ni,
  input logic          inc_i,
  input logic          dec_i,
  input logic [CW-1:0] count_i,
  input logic          flush_ack_i
);

  // A response handshake with nothing outstanding means the lookup answered twice.
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(dec_i && !inc_i && (count_i == {CW{1'b0}})));

  // Issue is gated by the credit check, so the counter can never pass its limit.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(inc_i && !dec_i && (count_i == CW'(MAX_OUTSTANDING))));

  // The flush acknowledge is a single-cycle pulse.
  a_ack_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni)
    flush_ack_i |=> !flush_ack_i);

endmodule

module snitch_icache_lookup_sched #(
  parameter int unsigned NR_PORTS        = 4,
  parameter int unsigned FETCH_AW        = 32,
  parameter int unsigned ID_WIDTH        = 2,
  parameter int unsigned LINE_WIDTH      = 128,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned PW              = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1,
  parameter int unsigned LID             = ID_WIDTH + PW
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  // Requester side
  input  logic [NR_PORTS*FETCH_AW-1:0] req_addr_i,
  input  logic [NR_PORTS*ID_WIDTH-1:0] req_id_i,
  input  logic [NR_PORTS-1:0]          req_valid_i,
  output logic [NR_PORTS-1:0]          req_ready_o,
  output logic [LINE_WIDTH-1:0]        rsp_data_o,
  output logic [ID_WIDTH-1:0]          rsp_id_o,
  output logic                         rsp_hit_o,
  output logic                         rsp_error_o,
  output logic [NR_PORTS-1:0]          rsp_valid_o,
  input  logic [NR_PORTS-1:0]          rsp_ready_i,
  // Lookup request side
  output logic [FETCH_AW-1:0]          lkp_addr_o,
  output logic [LID-1:0]               lkp_id_o,
  output logic                         lkp_valid_o,
  input  logic                         lkp_ready_i,
  // Lookup response side
  input  logic [LID-1:0]               lkp_rsp_id_i,
  input  logic [LINE_WIDTH-1:0]        lkp_rsp_data_i,
  input  logic                         lkp_rsp_hit_i,
  input  logic                         lkp_rsp_err_i,
  input  logic                         lkp_rsp_valid_i,
  output logic                         lkp_rsp_ready_o,
  // Flush control
  input  logic                         flush_req_i,
  output logic                         flush_ack_o,
  output logic                         lkp_flush_valid_o,
  input  logic                         lkp_flush_ready_i
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    ACK   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic            lock_q, lock_d;
  logic [PW-1:0]   lock_port_q, lock_port_d;
  logic [CW-1:0]   count_q, count_d;

  logic            accept_new_s;
  logic            arb_valid_s;
  logic [PW-1:0]   arb_port_s;
  logic            gnt_valid_s;
  logic [PW-1:0]   gnt_port_s;
  logic            lkp_hs_s;
  logic            rsp_hs_s;
  logic [PW-1:0]   rsp_port_s;
  logic            rsp_port_ok_s;
  logic            rsp_sel_ready_s;

  // Port index (base + off) modulo NR_PORTS; both operands are already below NR_PORTS.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    sum = (sum >= NR_PORTS) ? (sum - NR_PORTS) : sum;
    return PW'(sum);
  endfunction

  // Round-robin search: first valid requester at or after the rr pointer.
  always_comb begin
    arb_valid_s = 1'b0;
    arb_port_s  = {PW{1'b0}};
    for (int i = 0; i < int'(NR_PORTS); i++) begin
      if (!arb_valid_s && req_valid_i[wrap_add(rr_q, i)]) begin
        arb_valid_s = 1'b1;
        arb_port_s  = wrap_add(rr_q, i);
      end else begin
        arb_valid_s = arb_valid_s;
      end
    end
  end

  // A locked grant keeps presenting its request even once a drain has begun;
  // otherwise a fresh grant needs a free credit and an idle flush sequencer.
  always_comb begin
    if (lock_q) begin
      gnt_port_s  = lock_port_q;
      gnt_valid_s = req_valid_i[lock_port_q];
    end else begin
      gnt_port_s  = arb_port_s;
      gnt_valid_s = arb_valid_s && accept_new_s
                    && (count_q < CW'(MAX_OUTSTANDING));
    end
  end

  // Mux the granted requester onto the lookup request port.
  always_comb begin
    lkp_addr_o  = {FETCH_AW{1'b0}};
    lkp_id_o    = {LID{1'b0}};
    req_ready_o = {NR_PORTS{1'b0}};
    for (int i = 0; i < int'(NR_PORTS); i++) begin
      if (gnt_port_s == PW'(i)) begin
        lkp_addr_o     = req_addr_i[i*FETCH_AW +: FETCH_AW];
        lkp_id_o       = {gnt_port_s, req_id_i[i*ID_WIDTH +: ID_WIDTH]};
        req_ready_o[i] = gnt_valid_s && lkp_ready_i;
      end else begin
        req_ready_o[i] = 1'b0;
      end
    end
    lkp_valid_o = gnt_valid_s;
  end

  assign lkp_hs_s = gnt_valid_s && lkp_ready_i;

  // Steer the lookup response to the requester named by the upper ID bits;
  // an index with no matching port is swallowed so the lookup never stalls.
  always_comb begin
    rsp_port_s      = lkp_rsp_id_i[LID-1:ID_WIDTH];
    rsp_valid_o     = {NR_PORTS{1'b0}};
    rsp_port_ok_s   = 1'b0;
    rsp_sel_ready_s = 1'b0;
    for (int i = 0; i < int'(NR_PORTS); i++) begin
      rsp_valid_o[i]  = lkp_rsp_valid_i && (rsp_port_s == PW'(i));
      rsp_port_ok_s   = rsp_port_ok_s | (rsp_port_s == PW'(i));
      rsp_sel_ready_s = rsp_sel_ready_s | ((rsp_port_s == PW'(i)) && rsp_ready_i[i]);
    end
    lkp_rsp_ready_o = rsp_port_ok_s ? rsp_sel_ready_s : 1'b1;
  end

  assign rsp_data_o  = lkp_rsp_data_i;
  assign rsp_id_o    = lkp_rsp_id_i[ID_WIDTH-1:0];
  assign rsp_hit_o   = lkp_rsp_hit_i;
  assign rsp_error_o = lkp_rsp_err_i;
  assign rsp_hs_s    = lkp_rsp_valid_i && lkp_rsp_ready_o;

  // Credit counter: +1 per issued lookup, -1 per answered lookup, saturating at both ends.
  always_comb begin
    case ({lkp_hs_s, rsp_hs_s})
      2'b10:   count_d = (count_q < CW'(MAX_OUTSTANDING)) ? (count_q + CW'(1)) : count_q;
      2'b01:   count_d = (count_q != {CW{1'b0}}) ? (count_q - CW'(1)) : count_q;
      default: count_d = count_q;
    endcase
  end

  // Grant lock and rr pointer: lock on a stalled request, advance past the winner on handshake.
  always_comb begin
    if (lkp_hs_s) begin
      lock_d      = 1'b0;
      lock_port_d = lock_port_q;
      rr_d        = wrap_add(gnt_port_s, 1);
    end else if (gnt_valid_s) begin
      lock_d      = 1'b1;
      lock_port_d = gnt_port_s;
      rr_d        = rr_q;
    end else begin
      lock_d      = lock_q;
      lock_port_d = lock_port_q;
      rr_d        = rr_q;
    end
  end

  // Flush sequencer next state; the drain exit looks at next-cycle credit and
  // lock so the flush is offered the cycle right after the last response.
  always_comb begin
    case (state_q)
      IDLE:    state_d = flush_req_i ? DRAIN : IDLE;
      DRAIN:   state_d = ((count_d == {CW{1'b0}}) && !lock_d) ? FLUSH : DRAIN;
      FLUSH:   state_d = lkp_flush_ready_i ? ACK : FLUSH;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Flush sequencer outputs, decoded from the current state only.
  always_comb begin
    case (state_q)
      IDLE: begin
        accept_new_s      = 1'b1;
        lkp_flush_valid_o = 1'b0;
        flush_ack_o       = 1'b0;
      end
      FLUSH: begin
        accept_new_s      = 1'b0;
        lkp_flush_valid_o = 1'b1;
        flush_ack_o       = 1'b0;
      end
      ACK: begin
        accept_new_s      = 1'b0;
        lkp_flush_valid_o = 1'b0;
        flush_ack_o       = 1'b1;
      end
      default: begin
        accept_new_s      = 1'b0;
        lkp_flush_valid_o = 1'b0;
        flush_ack_o       = 1'b0;
      end
    endcase
  end

  // State registers; a reset abandons any flush and forgets in-flight lookups.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rr_q        <= {PW{1'b0}};
      lock_q      <= 1'b0;
      lock_port_q <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      lock_port_q <= lock_port_d;
      count_q     <= count_d;
    end
  end

  snitch_icache_lookup_sched_chk #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CW              (CW)
  ) i_chk (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .inc_i       (lkp_hs_s),
    .dec_i       (rsp_hs_s),
    .count_i     (count_q),
    .flush_ack_i (flush_ack_o)
  );

endmodule
